// File: rtl/dmem_resp.sv
// dmem_resp: word-addressed data memory with a 1-entry store buffer and store-to-load forwarding.
// Define DMEM_RESP_CLR_EN to zero the whole array after reset, with stop held high during the sweep.
module dmem_resp #(
   parameter int DEPTH_LOG2 = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_w,
   input  logic [3:0]  DWea,
   input  logic [31:0] Addr,
   input  logic [31:0] Data_wr,
   output logic [31:0] Data_rd,
   output logic        stop
);

   localparam int WORDS = 1 << DEPTH_LOG2;

   logic [31:0]           mem [WORDS];
   logic [DEPTH_LOG2-1:0] index;
   logic                  run;
   logic                  capture;
   logic                  commit;

   logic                  sb_valid;
   logic [DEPTH_LOG2-1:0] sb_idx;
   logic [31:0]           sb_data;
   logic [3:0]            sb_be;

   logic                  wr_en;
   logic [DEPTH_LOG2-1:0] wr_idx;
   logic [31:0]           wr_data;
   logic [3:0]            wr_be;

   // Byte offset and bits above the array size alias away.
   logic                  addr_unused;
   assign index       = Addr[DEPTH_LOG2+1:2];
   assign addr_unused = ^{Addr[31:DEPTH_LOG2+2], Addr[1:0]};

`ifdef DMEM_RESP_CLR_EN
   typedef enum logic {CLR, RUN} state_t;

   state_t                state;
   logic [DEPTH_LOG2-1:0] clr_cnt;

   // Sweep every word to zero once after reset; the final write also moves us to RUN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= CLR;
         clr_cnt <= '0;
         stop    <= 1'b1;
      end else if (state == CLR) begin
         clr_cnt <= clr_cnt + 1'b1;
         if (clr_cnt == '1) begin
            state <= RUN;
            stop  <= 1'b0;
         end
      end
   end

   assign run = (state == RUN);
`else
   assign run  = 1'b1;
   assign stop = 1'b0;
`endif

   assign capture = run && mem_w && (DWea != 4'b0000);
   assign commit  = run && sb_valid;

   // The buffer always takes a new store even when it is still committing the previous one;
   // the old entry drains to the array on that same edge, so no lane merging is ever needed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sb_valid <= 1'b0;
         sb_idx   <= '0;
         sb_data  <= '0;
         sb_be    <= '0;
      end else if (capture) begin
         sb_valid <= 1'b1;
         sb_idx   <= index;
         sb_data  <= Data_wr;
         sb_be    <= DWea;
      end else if (commit) begin
         sb_valid <= 1'b0;
      end
   end

   // Single array write port: the clear sweep owns it in CLR, the buffer commit in RUN.
   always_comb begin
      wr_en   = commit;
      wr_idx  = sb_idx;
      wr_data = sb_data;
      wr_be   = sb_be;
`ifdef DMEM_RESP_CLR_EN
      if (state == CLR) begin
         wr_en   = rst_n;
         wr_idx  = clr_cnt;
         wr_data = '0;
         wr_be   = 4'hF;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < 4; i++) begin
            if (wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
         end
      end
   end

   // Asynchronous read with per-lane forwarding from the pending buffered store.
   always_comb begin
      Data_rd = mem[index];
      for (int i = 0; i < 4; i++) begin
         if (sb_valid && (sb_idx == index) && sb_be[i]) Data_rd[8*i +: 8] = sb_data[8*i +: 8];
      end
      if (!run) Data_rd = '0;
   end

endmodule
